// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store port and the VGA
// object-table fetcher: CPU has priority, VGA is guaranteed a slot after a bounded CPU run.
module dmem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              freeze,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_q,
  output logic              vga_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wEn,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_CPU_RUN);

  owner_t            w_owner;
  owner_t            r_owner_q;
  logic [3:0]        r_run_cnt;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_cpu_q;
  logic              r_cpu_rd;
  logic              w_force_vga;
  logic              w_cpu_load;

  // Handshake: a requester holds req (and its address/data) until accepted.
  // CPU is accepted in any cycle where cpu_req=1 and cpu_stall=0; VGA is accepted
  // in the cycle vga_gnt=1. Read data returns on the following cycle.
  assign w_force_vga = vga_req & (r_run_cnt == RUN_MAX);

  always_comb begin
    w_owner = OWN_NONE;
    if (!reset)                       w_owner = OWN_NONE;
    else if (cpu_req && !w_force_vga) w_owner = OWN_CPU;
    else if (vga_req)                 w_owner = OWN_VGA;
  end

  always_comb begin
    ram_addr = r_last_addr;
    ram_wEn  = 1'b0;
    case (w_owner)
      OWN_CPU: begin
        ram_addr = cpu_addr;
        ram_wEn  = cpu_wren & ~freeze;
      end
      OWN_VGA: ram_addr = vga_addr;
      default: ;
    endcase
  end

  assign ram_dataIn = cpu_data;
  assign cpu_stall  = reset & cpu_req & (w_owner != OWN_CPU);
  assign vga_gnt    = (w_owner == OWN_VGA);
  assign vga_valid  = (r_owner_q == OWN_VGA);
  assign vga_q      = ram_dataOut;

  // Bypass lets load data reach the CPU the cycle after grant; the register holds it after.
  assign w_cpu_load = (r_owner_q == OWN_CPU) & r_cpu_rd;
  assign cpu_q      = w_cpu_load ? ram_dataOut : r_cpu_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner_q   <= OWN_NONE;
      r_run_cnt   <= 4'd0;
      r_last_addr <= '0;
      r_cpu_q     <= '0;
      r_cpu_rd    <= 1'b0;
    end else begin
      r_owner_q <= w_owner;
      if (w_owner != OWN_NONE) r_last_addr <= ram_addr;
      if (w_owner == OWN_CPU)  r_cpu_rd    <= ~cpu_wren;
      if (w_cpu_load)          r_cpu_q     <= ram_dataOut;
      if (!vga_req || w_owner == OWN_VGA)
        r_run_cnt <= 4'd0;
      else if (w_owner == OWN_CPU && r_run_cnt != RUN_MAX)
        r_run_cnt <= r_run_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed sequences, a vector table, and a randomized
// run checked against a cycle-level model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MAXR = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b1, cpu_wren = 1'b1, freeze = 1'b0, vga_req = 1'b1;
  logic [AW-1:0] cpu_addr = 12'h0AB, vga_addr = 12'h0CD;
  logic [DW-1:0] cpu_data = 32'hCAFE_F00D;
  logic [DW-1:0] cpu_q, vga_q, ram_dataIn, ram_dataOut;
  logic          cpu_stall, vga_gnt, vga_valid, ram_wEn;
  logic [AW-1:0] ram_addr;

  bit [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_RUN(MAXR)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall), .freeze(freeze),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_q(vga_q),
    .vga_valid(vga_valid), .ram_addr(ram_addr), .ram_wEn(ram_wEn),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  // clock / RAM model block
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, sample 1ns later
  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic fr, input logic vr,
                       input logic [AW-1:0] va);
    @(negedge clock);
    cpu_req = cr; cpu_wren = cw; cpu_addr = ca; cpu_data = cd;
    freeze = fr; vga_req = vr; vga_addr = va;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic          cr, cw, fr, vr;
    logic [AW-1:0] ca, va;
    logic          e_stall, e_gnt, e_wen;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[8];

  // random-phase model state
  logic [DW-1:0] shadow [0:15];
  int            run;
  int            vga_wait;
  logic [AW-1:0] m_last;
  logic [DW-1:0] m_cpu_q;
  logic          prev_vga_g;

  initial begin
    logic cr, cw, fr, vr, cpu_g, vga_g, force_v;
    logic [AW-1:0] ca, va, e_addr;
    logic [DW-1:0] cd;
    logic cpu_hold, vga_hold;

    // reset state with both requests asserted
    @(negedge clock); @(negedge clock); #1;
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_vga_gnt", vga_gnt, 0);
    chk("rst_ram_wen", ram_wEn, 0);
    chk("rst_vga_valid", vga_valid, 0);
    chk("rst_cpu_q", cpu_q, 0);
    chk("rst_ram_addr", ram_addr, 0);
    cpu_req = 1'b0; vga_req = 1'b0; cpu_wren = 1'b0;
    reset = 1'b1;
    idle();
    chk("idle_addr_after_rst", ram_addr, 0);

    // single CPU store then load
    drive(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, '0);
    chk("st_stall", cpu_stall, 0);
    chk("st_wen", ram_wEn, 1);
    chk("st_addr", ram_addr, 12'h010);
    chk("st_data", ram_dataIn, 32'hDEADBEEF);
    drive(1, 1, 12'h020, 32'h0000_0123, 0, 0, '0);
    chk("st2_wen", ram_wEn, 1);
    drive(1, 0, 12'h010, '0, 0, 0, '0);
    chk("ld_stall", cpu_stall, 0);
    chk("ld_wen", ram_wEn, 0);
    idle();
    chk("ld_cpu_q", cpu_q, 32'hDEADBEEF);
    idle();
    chk("ld_cpu_q_hold", cpu_q, 32'hDEADBEEF);

    // starvation guard: both requests held for 10 cycles
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 12'h040, '0, 0, 1, 12'h020);
      chk($sformatf("sg_gnt_c%0d", c), vga_gnt, (c == 4 || c == 9));
      chk($sformatf("sg_stall_c%0d", c), cpu_stall, (c == 4 || c == 9));
      chk($sformatf("sg_valid_c%0d", c), vga_valid, (c == 5));
      chk($sformatf("sg_addr_c%0d", c), ram_addr, (c == 4 || c == 9) ? 12'h020 : 12'h040);
      if (c == 5) chk("sg_vga_q", vga_q, 32'h0000_0123);
    end
    idle();
    chk("sg_valid_tail", vga_valid, 1);
    chk("sg_vga_q_tail", vga_q, 32'h0000_0123);

    // VGA only, then idle hold
    drive(0, 0, '0, '0, 0, 1, 12'h020);
    chk("vo_gnt", vga_gnt, 1);
    chk("vo_stall", cpu_stall, 0);
    chk("vo_wen", ram_wEn, 0);
    chk("vo_addr", ram_addr, 12'h020);
    idle();
    chk("vo_valid", vga_valid, 1);
    chk("vo_vga_q", vga_q, 32'h0000_0123);
    chk("vo_wen2", ram_wEn, 0);
    chk("hold_addr1", ram_addr, 12'h020);
    idle();
    chk("hold_valid", vga_valid, 0);
    chk("hold_addr2", ram_addr, 12'h020);
    chk("hold_wen", ram_wEn, 0);
    chk("hold_gnt", vga_gnt, 0);

    // frozen store is granted but not written
    drive(1, 0, 12'h010, '0, 0, 0, '0);
    drive(1, 1, 12'h030, 32'h55, 1, 0, '0);
    chk("fz_stall", cpu_stall, 0);
    chk("fz_wen", ram_wEn, 0);
    chk("fz_cpu_q_ld", cpu_q, 32'hDEADBEEF);
    drive(1, 0, 12'h030, '0, 0, 0, '0);
    chk("fz_cpu_q_store", cpu_q, 32'hDEADBEEF);
    idle();
    chk("fz_readback", cpu_q, 32'h0);

    // vector table, each row from a cleared run count
    vecs[0] = '{1,1,0,0, 12'h100, 12'h200, 0,0,1, 12'h100};
    vecs[1] = '{1,0,0,0, 12'h101, 12'h200, 0,0,0, 12'h101};
    vecs[2] = '{1,1,1,0, 12'h102, 12'h200, 0,0,0, 12'h102};
    vecs[3] = '{0,0,0,1, 12'h103, 12'h203, 0,1,0, 12'h203};
    vecs[4] = '{1,1,0,1, 12'h104, 12'h204, 0,0,1, 12'h104};
    vecs[5] = '{1,0,1,1, 12'h105, 12'h205, 0,0,0, 12'h105};
    vecs[6] = '{0,1,0,0, 12'h106, 12'h206, 0,0,0, 12'h105};
    vecs[7] = '{0,0,1,1, 12'h107, 12'h207, 0,1,0, 12'h207};
    foreach (vecs[i]) begin
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, 32'hA500_0000 | i, vecs[i].fr, vecs[i].vr, vecs[i].va);
      chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].e_stall);
      chk($sformatf("vec%0d_gnt", i), vga_gnt, vecs[i].e_gnt);
      chk($sformatf("vec%0d_wen", i), ram_wEn, vecs[i].e_wen);
      chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
      idle();
    end

    // randomized run against the model
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    drive(1, 0, 12'h300, '0, 0, 0, '0);
    run = 0; vga_wait = 0; m_last = 12'h300; m_cpu_q = '0; prev_vga_g = 1'b0;
    cpu_hold = 1'b0; vga_hold = 1'b0;
    cr = 0; cw = 0; ca = '0; cd = '0; vr = 0; va = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cpu_hold) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1);
        ca = 12'h300 + 12'($urandom_range(0, 15));
        cd = $urandom;
      end
      if (!vga_hold) begin
        vr = $urandom_range(0, 1);
        va = 12'h300 + 12'($urandom_range(0, 15));
      end
      fr = ($urandom_range(0, 3) == 0);
      drive(cr, cw, ca, cd, fr, vr, va);

      force_v = vr && (run == MAXR);
      cpu_g   = cr && !force_v;
      vga_g   = !cpu_g && vr;
      e_addr  = cpu_g ? ca : (vga_g ? va : m_last);

      chk("rnd_stall", cpu_stall, cr && !cpu_g);
      chk("rnd_gnt", vga_gnt, vga_g);
      chk("rnd_wen", ram_wEn, cpu_g && cw && !fr);
      chk("rnd_addr", ram_addr, e_addr);
      chk("rnd_valid", vga_valid, prev_vga_g);
      chk("rnd_cpu_q", cpu_q, m_cpu_q);
      if (prev_vga_g && exp_q.size() > 0) chk("rnd_vga_q", vga_q, exp_q.pop_front());

      if (vga_g) begin
        chk("rnd_vga_wait_bound", (vga_wait <= MAXR), 1);
        exp_q.push_back(shadow[va[3:0]]);
        vga_wait = 0;
      end else if (vr) begin
        vga_wait++;
      end
      if (cpu_g && !cw) m_cpu_q = shadow[ca[3:0]];
      if (cpu_g && cw && !fr) shadow[ca[3:0]] = cd;
      if (vga_g || !vr) run = 0;
      else if (cpu_g && run < MAXR) run++;
      if (cpu_g || vga_g) m_last = e_addr;
      prev_vga_g = vga_g;
      cpu_hold = cr && !cpu_g;
      vga_hold = vr && !vga_g;
    end
    idle();
    chk("rnd_valid_tail", vga_valid, prev_vga_g);
    if (prev_vga_g && exp_q.size() > 0) chk("rnd_vga_q_tail", vga_q, exp_q.pop_front());
    chk("rnd_queue_empty", exp_q.size(), 0);
    idle();

    // asynchronous reset while a VGA read is in flight
    drive(0, 0, '0, '0, 0, 1, 12'h020);
    chk("ar_gnt", vga_gnt, 1);
    @(posedge clock); #1;
    chk("ar_valid_pre", vga_valid, 1);
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h040; vga_req = 1'b1; vga_addr = 12'h020;
    reset = 1'b0;
    #1;
    chk("ar_valid", vga_valid, 0);
    chk("ar_stall", cpu_stall, 0);
    chk("ar_gnt_rst", vga_gnt, 0);
    chk("ar_wen", ram_wEn, 0);
    chk("ar_cpu_q", cpu_q, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("ar_rel_stall", cpu_stall, 0);
    chk("ar_rel_gnt", vga_gnt, 0);
    for (int c = 1; c <= 4; c++) begin
      drive(1, 0, 12'h040, '0, 0, 1, 12'h020);
      chk($sformatf("ar_run_gnt_c%0d", c), vga_gnt, (c == 4));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the processor's load/store port and the VGA object-table fetcher, which reads dino/obstacle records during blanking.
- Sits between processor/VGAController and RAM.
- Fixed priority to the CPU, with a starvation guard that forces a VGA slot after a bounded CPU run.
- Returns read data one cycle after grant. Blocks CPU writes while the game is frozen.

Parameters:
- ADDR_W, 12, RAM address width
- DATA_W, 32, RAM data width
- MAX_CPU_RUN, 4, max consecutive CPU grants while vga_req is pending; range 1..15

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- cpu_req  in  1  CPU memory access this cycle (lw or sw)
- cpu_wren  in  1  CPU store, qualified by cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_data  in  DATA_W  CPU store data
- cpu_q  out  DATA_W  CPU load data, valid the cycle after a CPU read grant
- cpu_stall  out  1  CPU must hold its request; access not granted this cycle
- freeze  in  1  game over; suppresses RAM writes
- vga_req  in  1  VGA read request, held until granted
- vga_addr  in  ADDR_W  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_q  out  DATA_W  VGA read data
- vga_valid  out  1  vga_q valid; asserted the cycle after vga_gnt
- ram_addr  out  ADDR_W  to RAM addr
- ram_wEn  out  1  to RAM wEn
- ram_dataIn  out  DATA_W  to RAM dataIn
- ram_dataOut  in  DATA_W  from RAM, 1-cycle read latency

Behaviour:
- Grant decision is combinational each cycle; owner ∈ {NONE, CPU, VGA}.
  - force_vga = vga_req & (run_cnt == MAX_CPU_RUN).
  - CPU granted if cpu_req & ~force_vga.
  - Else VGA granted if vga_req.
  - Else NONE.
- cpu_stall = cpu_req & (owner != CPU). vga_gnt = (owner == VGA).
- RAM drive:
  - CPU owner: ram_addr = cpu_addr, ram_dataIn = cpu_data, ram_wEn = cpu_wren & ~freeze.
  - VGA owner: ram_addr = vga_addr, ram_wEn = 0.
  - NONE: ram_addr holds the last driven address (registered copy), ram_wEn = 0.
  - ram_dataIn = cpu_data always.
- Return path: registered owner_q captures owner on each rising edge.
  - cpu_q register loads ram_dataOut when owner_q == CPU and the previous CPU access was a read; otherwise it holds.
  - vga_q = ram_dataOut combinationally. vga_valid = (owner_q == VGA), registered.
- run_cnt (4 bits):
  - Increments on a CPU grant while vga_req = 1, saturating at MAX_CPU_RUN.
  - Clears to 0 on a VGA grant or any cycle with vga_req = 0.
- Frozen store: with freeze = 1, a CPU store is still granted (cpu_stall = 0) but not written; the processor retires it as a no-op. Reads are unaffected.
- Simultaneous requests with run_cnt < MAX_CPU_RUN: CPU wins; VGA keeps vga_req and waits.
- After a forced VGA slot, run_cnt = 0, so the CPU wins again next cycle if requesting.
- Worst-case latencies:
  - VGA: MAX_CPU_RUN+1 cycles from request to grant.
  - CPU: 1 stall cycle per forced slot.
- Reset (reset = 0, asynchronous):
  - owner_q = NONE, run_cnt = 0, cpu_q = 0, vga_valid = 0, last address = 0.
  - Combinational outputs are forced: cpu_stall = 0, vga_gnt = 0, ram_wEn = 0.
- Reset mid-operation: an in-flight read's vga_valid/cpu_q update is discarded. After release, arbitration restarts on the first rising edge.

Test Plan:
- Single CPU access: reset release, then cpu_req = 1, cpu_wren = 1, addr 0x010, data 0xDEADBEEF. Required: ram_wEn = 1, cpu_stall = 0. Next cycle a CPU read of 0x010 gives cpu_q = 0xDEADBEEF one cycle after grant.
- Starvation guard: cpu_req and vga_req both held high, MAX_CPU_RUN = 4. Required: CPU granted cycles 0–3, VGA granted cycle 4 with cpu_stall = 1, vga_valid = 1 in cycle 5, CPU granted again in cycle 5.
- VGA only: vga_req with vga_addr 0x020 preloaded to 0x00000123 and no CPU request. Required: vga_gnt same cycle, next cycle vga_valid = 1 and vga_q = 0x00000123, ram_wEn = 0 throughout.
- Freeze: freeze = 1 and a CPU store of 0x55 to 0x030 (previously 0x0). Required: cpu_stall = 0, ram_wEn = 0, and a subsequent read returns 0x0.
- Idle hold: no requests after a VGA read of 0x020. Required: ram_addr stays 0x020, ram_wEn = 0, vga_valid = 0, and run_cnt does not increment.
- Asynchronous reset mid-read: reset = 0 asserted between a VGA grant and the next edge. Required: vga_valid = 0 immediately, run_cnt = 0, and after release a new CPU request is granted with no stall.
